// File: rtl/instr_encoder.sv
// instr_encoder
//   Turns a stream of instruction requests (op_kind plus register, immediate
//   and target fields) into 32-bit MIPS-style machine words. The words are
//   queued in a small FIFO and written to sequential instruction-memory
//   addresses, starting at base_addr.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   start, base_addr  open a load session (IDLE only), first byte address
//   op_valid/op_ready request handshake; op_kind, rs, rt, rd, imm, target
//   finish            close the session once every queued word is written
//   imem_we/addr/wdata/imem_ready  instruction-memory write handshake
//   busy, done, err, count  status: session active, one-cycle end pulse,
//                     sticky illegal-op flag, words written this session
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        finish,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic        imem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    occ_q, occ_d;
  logic [31:0]    addr_q, addr_d;
  logic [15:0]    count_q, count_d;
  logic           err_q, err_d;
  logic           op_ready_q, op_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [31:0]    enc_word;
  logic           enc_legal;
  logic           accept, push, pop, fifo_empty;

  // Instruction encoding
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (op_kind)
      4'd0: enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000}; // add
      4'd1: enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010}; // sub
      4'd2: enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100}; // and
      4'd3: enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101}; // or
      4'd4: enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010}; // slt
      4'd5: enc_word = {6'b100011, rs, rt, imm};                      // lw
      4'd6: enc_word = {6'b101011, rs, rt, imm};                      // sw
      4'd7: enc_word = {6'b001000, rs, rt, imm};                      // addi
      4'd8: enc_word = {6'b000100, rs, rt, imm};                      // beq
      4'd9: enc_word = {6'b000010, target};                           // j
      default: enc_legal = 1'b0;
    endcase
  end

  assign fifo_empty = (occ_q == '0);
  assign accept     = op_valid && op_ready_q;
  // Illegal ops complete the handshake but never reach the FIFO.
  assign push       = accept && enc_legal;
  assign pop        = !fifo_empty && imem_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      addr_d   = addr_q + 32'd4;
      count_d  = count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    if (accept && !enc_legal) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          count_d = 16'h0;
          err_d   = 1'b0;
        end
      end
      S_RUN:   if (finish) state_d = S_DRAIN;
      // Leave as soon as the final pop empties the FIFO, so done follows
      // the last completed write by one cycle.
      S_DRAIN: if (occ_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered: computed from next-state values.
    op_ready_d = (state_d == S_RUN) && (occ_d != FULL_OCC);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      addr_q     <= 32'h0;
      count_q    <= 16'h0;
      err_q      <= 1'b0;
      op_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      op_ready_q <= op_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // FIFO storage carries data only; validity is tracked by occ_q, so the
  // array needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  assign op_ready   = op_ready_q;
  assign imem_we    = !fifo_empty;
  // Head is forced to zero when empty so the bus is quiet after reset.
  assign imem_wdata = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  assign imem_addr  = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [3:0]  op_kind = 4'd0;
  logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic [15:0] imm = 16'h0;
  logic [25:0] target = 26'h0;
  logic        finish = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        imem_ready = 1'b0;
  logic        busy, done, err;
  logic [15:0] count;

  instr_encoder #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .finish(finish), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ready(imem_ready),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  // Write / done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we && imem_ready) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      $display("write addr=%h data=%h count=%0d", imem_addr, imem_wdata, count);
    end
    if (done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic send_op(input vec_t v, input int limit, output bit acc);
    op_kind = v.kind; rs = v.rs; rt = v.rt; rd = v.rd;
    imm = v.imm; target = v.target;
    op_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < limit && !acc; c++) begin
      sample();
      if (op_ready) acc = 1'b1;
      tick();
    end
    op_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int limit);
    for (int c = 0; c < limit && wr_addr_q.size() < n; c++) sample();
    check("write_arrival", wr_addr_q.size(), n);
  endtask

  task automatic start_session(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic end_session();
    done_cnt = 0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    sample();
    check("done_pulse_count", done_cnt, 1);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    bit acc;
    int nlegal;
    int last_wr, done_at, done_cycles;
    logic [31:0] base;

    //          kind  rs     rt     rd     imm        target        legal word
    vecs[0]  = '{4'd0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h00221820};
    vecs[1]  = '{4'd1, 5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       1'b1, 32'h00853022};
    vecs[2]  = '{4'd2, 5'd7,  5'd8,  5'd9,  16'h1234, 26'h0,       1'b1, 32'h00E84824};
    vecs[3]  = '{4'd3, 5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       1'b1, 32'h03FFF825};
    vecs[4]  = '{4'd4, 5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       1'b1, 32'h0022182A};
    vecs[5]  = '{4'd5, 5'd29, 5'd8,  5'd17, 16'h0004, 26'h0,       1'b1, 32'h8FA80004};
    vecs[6]  = '{4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0100000, 1'b1, 32'h08100000};
    vecs[7]  = '{4'd12,5'd1,  5'd2,  5'd3,  16'h0001, 26'h0,       1'b0, 32'h0};
    vecs[8]  = '{4'd6, 5'd2,  5'd3,  5'd31, 16'hFFFC, 26'h0,       1'b1, 32'hAC43FFFC};
    vecs[9]  = '{4'd7, 5'd0,  5'd1,  5'd0,  16'h1234, 26'h0,       1'b1, 32'h20011234};
    vecs[10] = '{4'd8, 5'd5,  5'd6,  5'd7,  16'h8000, 26'h0,       1'b1, 32'h10A68000};
    vecs[11] = '{4'd9, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};
    vecs[12] = '{4'd15,5'd0,  5'd0,  5'd0,  16'h0000, 26'h0,       1'b0, 32'h0};

    // Reset state
    tick(); tick(); tick();
    reset = 1'b0;
    sample();
    check("rst_op_ready", op_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_count", count, 0);
    tick();

    // Session A: every encoding, imem always ready
    base = 32'h0040_0000;
    imem_ready = 1'b1;
    start_session(base);
    sample();
    check("A_busy", busy, 1);
    tick();
    nlegal = 0;
    for (int i = 0; i < NV; i++) begin
      send_op(vecs[i], 5, acc);
      check($sformatf("A%0d_accept", i), acc, 1);
      if (vecs[i].legal) begin
        wait_writes(nlegal + 1, 10);
        if (wr_addr_q.size() > nlegal) begin
          check($sformatf("A%0d_data", i), wr_data_q[nlegal], vecs[i].word);
          check($sformatf("A%0d_addr", i), wr_addr_q[nlegal], base + 32'(4 * nlegal));
        end
        nlegal++;
        tick();
        sample();
        check($sformatf("A%0d_count", i), count, 32'(nlegal));
      end else begin
        tick(); tick();
        sample();
        check($sformatf("A%0d_err", i), err, 1);
        check($sformatf("A%0d_no_write", i), wr_addr_q.size(), nlegal);
        check($sformatf("A%0d_count_hold", i), count, 32'(nlegal));
      end
      tick();
    end
    sample();
    check("A_err_sticky", err, 1);
    end_session();

    // Session B: stalled memory, FIFO fills at 4, fifth op waits
    base = 32'h0000_1000;
    imem_ready = 1'b0;
    start_session(base);
    sample();
    check("B_err_cleared", err, 0);
    check("B_count_cleared", count, 0);
    check("B_addr_base", imem_addr, base);
    tick();
    for (int i = 0; i < 4; i++) begin
      send_op(vecs[i], 3, acc);
      check($sformatf("B%0d_accept", i), acc, 1);
    end
    send_op(vecs[4], 3, acc);
    check("B4_blocked", acc, 0);
    sample();
    check("B_full_op_ready", op_ready, 0);
    check("B_stall_we", imem_we, 1);
    check("B_stall_addr", imem_addr, base);
    check("B_stall_wdata", imem_wdata, vecs[0].word);
    tick();
    imem_ready = 1'b1;
    send_op(vecs[4], 10, acc);
    check("B4_accept_after_drain", acc, 1);
    wait_writes(5, 20);
    for (int i = 0; i < 5 && i < wr_addr_q.size(); i++) begin
      check($sformatf("B%0d_data", i), wr_data_q[i], vecs[i].word);
      check($sformatf("B%0d_addr", i), wr_addr_q[i], base + 32'(4 * i));
    end
    tick();
    sample();
    check("B_count", count, 5);
    tick();
    end_session();

    // Session C: finish with two words queued, op in the finish cycle
    base = 32'h0000_2000;
    imem_ready = 1'b0;
    start_session(base);
    tick();
    send_op(vecs[0], 3, acc);
    check("C0_accept", acc, 1);
    finish = 1'b1;
    send_op(vecs[5], 1, acc);
    finish = 1'b0;
    check("C1_accept_with_finish", acc, 1);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) tick();
    sample();
    check("C_stall_no_done", done_cnt, 0);
    check("C_stall_busy", busy, 1);
    check("C_stall_op_ready", op_ready, 0);
    check("C_stall_no_write", wr_addr_q.size(), 0);
    tick();
    imem_ready = 1'b1;
    last_wr = -10; done_at = -1; done_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (imem_we) last_wr = c;
      if (done) begin done_cycles++; done_at = c; end
      tick();
    end
    check("C_done_cycles", done_cycles, 1);
    check("C_done_after_last_write", done_at, last_wr + 1);
    check("C_write_total", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("C1_addr", wr_addr_q[1], base + 32'd4);
      check("C1_data", wr_data_q[1], vecs[5].word);
    end
    sample();
    check("C_busy_end", busy, 0);
    check("C_count_end", count, 2);
    tick();

    // Session D: reset mid-session with three words queued
    base = 32'h0000_3000;
    imem_ready = 1'b1;
    start_session(base);
    tick();
    send_op(vecs[1], 3, acc);
    wait_writes(1, 10);
    tick();
    imem_ready = 1'b0;
    for (int i = 2; i < 5; i++) begin
      send_op(vecs[i], 3, acc);
      check($sformatf("D%0d_accept", i), acc, 1);
    end
    sample();
    check("D_pre_count", count, 1);
    check("D_pre_we", imem_we, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    check("D_rst_we", imem_we, 0);
    check("D_rst_op_ready", op_ready, 0);
    check("D_rst_count", count, 0);
    check("D_rst_busy", busy, 0);
    check("D_rst_addr", imem_addr, 0);
    tick();
    imem_ready = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int c = 0; c < 6; c++) tick();
    sample();
    check("D_no_writes_after_reset", wr_addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of encoded-word FIFO entries, a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: opens a load session; honoured in IDLE only.
REQ-005 SHALL have port base_addr, input, 32 bits: first instruction-memory byte address; word-aligned.
REQ-006 SHALL have port op_valid, input, 1 bit: the op_* fields hold a request.
REQ-007 SHALL have port op_ready, output, 1 bit: a request is accepted on op_valid && op_ready.
REQ-008 SHALL have port op_kind, input, 4 bits: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 addi, 8 beq, 9 j; 10-15 are illegal.
REQ-009 SHALL have ports rs, rt and rd, each input, 5 bits: register fields.
REQ-010 SHALL have ports imm, input, 16 bits, and target, input, 26 bits: immediate and jump target, passed through unmodified.
REQ-011 SHALL have port finish, input, 1 bit: ends the session after the FIFO drains.
REQ-012 SHALL have ports imem_we, output, 1 bit; imem_addr, output, 32 bits; and imem_wdata, output, 32 bits: the instruction-memory write request.
REQ-013 SHALL have port imem_ready, input, 1 bit: a write completes on imem_we && imem_ready.
REQ-014 SHALL have ports busy, output, 1 bit; done, output, 1 bit, pulse; err, output, 1 bit, sticky; and count, output, 16 bits: words written this session.

Function
REQ-015 SHALL encode R-type ops (kinds 0-4) as opcode 000000 | rs | rt | rd | shamt 00000 | funct, with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
REQ-016 SHALL encode I-type ops as opcode | rs | rt | imm, with opcode 100011 lw, 101011 sw, 001000 addi, 000100 beq.
REQ-017 SHALL encode j as opcode 000010 | target.
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on start: imem_addr <= base_addr, count <= 0, err <= 0.
- RUN to DRAIN on finish; an op offered in the same cycle is accepted if op_ready is high.
- DRAIN to DONE once the FIFO is empty with no write outstanding.
- DONE to IDLE unconditionally after one cycle.
REQ-019 SHALL drive op_ready = (state == RUN) && FIFO not full, with no bypass path.
REQ-020 SHALL ignore start in any state other than IDLE.
REQ-021 SHALL push the encoded word on acceptance; the earliest imem_we is the cycle after acceptance.
REQ-022 SHALL drive imem_we = FIFO not empty and imem_wdata = FIFO head, both from registered state.
REQ-023 SHALL hold imem_wdata and imem_addr stable while imem_we && !imem_ready.
REQ-024 SHALL, on each completed write, pop the FIFO, add 4 to imem_addr (modulo 2^32) and add 1 to count (wrapping at 16 bits).
REQ-025 SHALL, when push and pop occur in the same cycle, perform both and leave occupancy unchanged; the same holds when the FIFO is full at the start of that cycle.
REQ-026 SHALL complete the handshake for an illegal op_kind, then drop the request: no FIFO push, err <= 1.
REQ-027 SHALL hold err until the next start or reset.
REQ-028 SHALL drive busy = state != IDLE.
REQ-029 SHALL assert done high for exactly the single cycle spent in DONE.

Reset
REQ-030 SHALL, on reset, force:
- state IDLE, FIFO empty;
- op_ready, imem_we, busy, done and err to 0;
- imem_addr, imem_wdata and count to 0.
REQ-031 SHALL give reset priority over all other inputs and discard queued words and in-flight writes mid-session.

Verification
REQ-032 SHALL cover: start with base_addr 0x00400000, then add rd=3 rs=1 rt=2, with imem_ready=1 -> one write of 0x00221820 at 0x00400000, count=1.
REQ-033 SHALL cover: lw rt=8 rs=29 imm=0x0004, then j target=0x0100000 -> writes 0x8FA80004 then 0x08100000 at consecutive addresses.
REQ-034 SHALL cover: imem_ready=0 with 5 ops offered and DEPTH=4 -> op_ready low after the 4th acceptance; after imem_ready=1, 5 writes at base+0 through base+16.
REQ-035 SHALL cover: op_kind=12 offered -> accepted, err=1, no write, count unchanged; the next legal op is written at the unchanged address.
REQ-036 SHALL cover: finish with 2 words queued -> done pulses for 1 cycle after the last write completes; then busy=0.
REQ-037 SHALL cover: reset asserted with 3 words queued -> next cycle imem_we=0, op_ready=0, count=0, no further writes.
